// File: rtl/sqrt_ram_sequencer_pkg.sv
// rtl/sqrt_ram_sequencer_pkg.sv - shared constants for the RAM square-root sequencer
//
// Purpose : default widths, the 3-bit FSM state encoding and the zero-extend
//           width used when a root is written back into a RAM word.
// Ports   : none (package).

package sqrt_ram_sequencer_pkg;

  localparam int SEQ_ADDR_W = 4;
  localparam int SEQ_DATA_W = 8;
  localparam int SEQ_ROOT_W = SEQ_DATA_W / 2;

  // Number of zero bits placed above a root to fill a RAM word.
  localparam int SEQ_ZEXT_W = SEQ_DATA_W - SEQ_ROOT_W;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;
  localparam logic [2:0] ST_WRITE   = 3'd5;
  localparam logic [2:0] ST_NEXT    = 3'd6;
  localparam logic [2:0] ST_FIN     = 3'd7;

  function automatic int zext_w(input int data_w, input int root_w);
    return data_w - root_w;
  endfunction

endpackage

// File: rtl/sqrt_seq_addr_gen.sv
// rtl/sqrt_seq_addr_gen.sv - address window walker for the RAM square-root sequencer
//
// Purpose : holds the captured window end, the current RAM address (wrapping
//           modulo 2**ADDR_W), the last-word compare and the completed-word count.
// Ports   :
//   i_clk        clock, rising edge
//   i_resetn     asynchronous active-low reset
//   i_load       accepted batch start: capture window, restart count
//   i_first      first address of the window
//   i_last       last address of the window (inclusive)
//   i_advance    one word finished: bump count, step address unless last
//   o_addr       current RAM address
//   o_is_last    current address equals the captured last address
//   o_word_cnt   words completed in the current/last batch

module sqrt_seq_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_first,
  input  logic [ADDR_W-1:0] i_last,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_is_last,
  output logic [ADDR_W:0]   o_word_cnt
);

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_C = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W:0]   r_cnt;
  logic              w_is_last;

  // The window is inclusive and may wrap, so termination is an equality
  // test against the captured end rather than a magnitude compare.
  assign w_is_last = (r_addr == r_last);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_addr <= '0;
      r_last <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_addr <= i_first;
      r_last <= i_last;
      r_cnt  <= '0;
    end else if (i_advance) begin
      r_cnt <= r_cnt + ONE_C;
      if (!w_is_last) begin
        r_addr <= r_addr + ONE_A;
      end
    end
  end

  assign o_addr     = r_addr;
  assign o_is_last  = w_is_last;
  assign o_word_cnt = r_cnt;

endmodule

// File: rtl/sqrt_ram_sequencer.sv
// rtl/sqrt_ram_sequencer.sv - batch sequencer feeding a RAM window through a sqrt engine
//
// Purpose : on Go, walks RAM addresses FirstAddr..LastAddr (inclusive, wrapping),
//           reads each word, runs it through the shared square-root engine and
//           writes the zero-extended root back in place.
// Optional: define SQRT_SEQ_CHECK_EN to add a root range checker (ChkErr/ChkAddr).
// Ports   :
//   CLK, ResetN          clock (rising) / asynchronous active-low reset
//   Go                   batch start, sampled only while idle
//   FirstAddr, LastAddr  window bounds, captured on an accepted Go
//   Addr, WData, WE      RAM address, write data, write enable
//   RData                RAM read data, valid the cycle after Addr
//   EngStart, EngN       engine start pulse and radicand (held while computing)
//   EngDone, EngRoot     engine result valid / result
//   Busy, Done           batch in progress / one-cycle end-of-batch pulse
//   WordCnt              words completed in current/last batch
//   ChkErr, ChkAddr      (SQRT_SEQ_CHECK_EN) sticky bad-root flag and its address

module sqrt_ram_sequencer
  import sqrt_ram_sequencer_pkg::*;
#(
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int DATA_W = SEQ_DATA_W,
  parameter int ROOT_W = SEQ_ROOT_W
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              Go,
  input  logic [ADDR_W-1:0] FirstAddr,
  input  logic [ADDR_W-1:0] LastAddr,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] WData,
  output logic              WE,
  input  logic [DATA_W-1:0] RData,
  output logic              EngStart,
  output logic [DATA_W-1:0] EngN,
  input  logic              EngDone,
  input  logic [ROOT_W-1:0] EngRoot,
  output logic              Busy,
  output logic              Done,
`ifdef SQRT_SEQ_CHECK_EN
  output logic              ChkErr,
  output logic [ADDR_W-1:0] ChkAddr,
`endif
  output logic [ADDR_W:0]   WordCnt
);

  localparam int ZEXT_W = zext_w(DATA_W, ROOT_W);

  logic [2:0]        r_state;
  logic              r_busy;
  logic [DATA_W-1:0] r_engn;
  logic [DATA_W-1:0] r_wdata;

  logic              w_load;
  logic              w_advance;
  logic              w_is_last;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W:0]   w_word_cnt;

  assign w_load    = (r_state == ST_IDLE) && Go;
  assign w_advance = (r_state == ST_NEXT);

  sqrt_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_clk      (CLK),
    .i_resetn   (ResetN),
    .i_load     (w_load),
    .i_first    (FirstAddr),
    .i_last     (LastAddr),
    .i_advance  (w_advance),
    .o_addr     (w_addr),
    .o_is_last  (w_is_last),
    .o_word_cnt (w_word_cnt)
  );

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_engn  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Go) begin
            r_busy  <= 1'b1;
            r_state <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          // Registered RAM read lands now; EngN is then frozen until the
          // next word's RD_WAIT, which covers the whole engine computation.
          r_engn  <= RData;
          r_state <= ST_START;
        end
        ST_START: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (EngDone) begin
            r_wdata <= {{ZEXT_W{1'b0}}, EngRoot};
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: r_state <= ST_NEXT;
        ST_NEXT:  r_state <= w_is_last ? ST_FIN : ST_RD_ADDR;
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset drops WE immediately, with no clock needed to abort a write.
  assign WE       = (r_state == ST_WRITE);
  assign EngStart = (r_state == ST_START);
  assign Done     = (r_state == ST_FIN);
  assign Busy     = r_busy;
  assign EngN     = r_engn;
  assign WData    = r_wdata;
  assign Addr     = w_addr;
  assign WordCnt  = w_word_cnt;

`ifdef SQRT_SEQ_CHECK_EN
  localparam int CHK_W = DATA_W + 2;
  localparam logic [CHK_W-1:0] ONE_X = {{(CHK_W-1){1'b0}}, 1'b1};

  logic              r_chk_err;
  logic [ADDR_W-1:0] r_chk_addr;
  logic [CHK_W-1:0]  w_root_x;
  logic [CHK_W-1:0]  w_root_p1;
  logic [CHK_W-1:0]  w_n_x;
  logic [CHK_W-1:0]  w_lo;
  logic [CHK_W-1:0]  w_hi;
  logic              w_viol;

  // Two spare bits keep (root+1)^2 from overflowing for the largest root.
  assign w_root_x  = {{(CHK_W-ROOT_W){1'b0}}, r_wdata[ROOT_W-1:0]};
  assign w_root_p1 = w_root_x + ONE_X;
  assign w_n_x     = {2'b00, r_engn};
  assign w_lo      = w_root_x * w_root_x;
  assign w_hi      = w_root_p1 * w_root_p1;
  assign w_viol    = (w_n_x < w_lo) || (w_n_x >= w_hi);

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      r_chk_err  <= 1'b0;
      r_chk_addr <= '0;
    end else if (w_load) begin
      r_chk_err <= 1'b0;
    end else if ((r_state == ST_WRITE) && w_viol && !r_chk_err) begin
      // Only the first bad word of a batch is recorded.
      r_chk_err  <= 1'b1;
      r_chk_addr <= w_addr;
    end
  end

  assign ChkErr  = r_chk_err;
  assign ChkAddr = r_chk_addr;
`endif

endmodule

// File: tb/tb_sqrt_ram_sequencer.sv
// tb/tb_sqrt_ram_sequencer.sv - self-checking bench for sqrt_ram_sequencer

module tb_sqrt_ram_sequencer;
  import sqrt_ram_sequencer_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int RW    = 4;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          ResetN = 1'b0;
  logic          Go = 1'b0;
  logic [AW-1:0] FirstAddr = '0;
  logic [AW-1:0] LastAddr = '0;
  logic [AW-1:0] Addr;
  logic [DW-1:0] WData;
  logic          WE;
  logic [DW-1:0] RData = '0;
  logic          EngStart;
  logic [DW-1:0] EngN;
  wire           EngDone;
  logic [RW-1:0] EngRoot = '0;
  logic          Busy;
  logic          Done;
  logic [AW:0]   WordCnt;
`ifdef SQRT_SEQ_CHECK_EN
  logic          ChkErr;
  logic [AW-1:0] ChkAddr;
`endif

  logic eng_done_m = 1'b0;
  logic eng_done_force = 1'b0;
  assign EngDone = eng_done_m | eng_done_force;

  int n_checks = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  sqrt_ram_sequencer dut (
    .CLK       (CLK),
    .ResetN    (ResetN),
    .Go        (Go),
    .FirstAddr (FirstAddr),
    .LastAddr  (LastAddr),
    .Addr      (Addr),
    .WData     (WData),
    .WE        (WE),
    .RData     (RData),
    .EngStart  (EngStart),
    .EngN      (EngN),
    .EngDone   (EngDone),
    .EngRoot   (EngRoot),
    .Busy      (Busy),
    .Done      (Done),
`ifdef SQRT_SEQ_CHECK_EN
    .ChkErr    (ChkErr),
    .ChkAddr   (ChkAddr),
`endif
    .WordCnt   (WordCnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference square root: largest r with r*r <= n, optionally corrupted.
  bit corrupt_25 = 1'b0;
  function automatic int model_root(input int n);
    int r = 0;
    if (corrupt_25 && n == 25) return 3;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  // Single-port RAM, one-cycle registered read, write log kept in order.
  logic [DW-1:0] mem [DEPTH];
  int wr_addr_q[$];
  int wr_data_q[$];
  always @(posedge CLK) begin
    RData <= mem[Addr];
    if (WE) begin
      mem[Addr] = WData;
      wr_addr_q.push_back(int'(Addr));
      wr_data_q.push_back(int'(WData));
    end
  end

  // Engine: EngDone appears eng_lat cycles after the edge that takes EngStart.
  int eng_lat = 1;
  int eng_rem = 0;
  int n_starts = 0;
  logic [DW-1:0] eng_n = '0;
  initial begin
    forever begin
      @(negedge CLK);
      eng_done_m = 1'b0;
      if (!ResetN) begin
        eng_rem = 0;
      end else if (eng_rem > 0) begin
        check_val("engn_stable", EngN, eng_n);
        eng_rem--;
        if (eng_rem == 0) begin
          eng_done_m = 1'b1;
          EngRoot = RW'(model_root(int'(eng_n)));
        end
      end
      if (EngStart) begin
        n_starts++;
        eng_n = EngN;
        eng_rem = eng_lat + 1;
      end
    end
  end

  task automatic run_batch(input int first, input int last, input int lat, input bit glitch, output int cycles);
    logic [DW-1:0] orig [DEPTH];
    logic [DW-1:0] expm [DEPTH];
    int n, a, starts0, busy_gaps;
    orig = mem;
    expm = mem;
    n = ((last - first + DEPTH) % DEPTH) + 1;
    for (int i = 0; i < n; i++) begin
      a = (first + i) % DEPTH;
      expm[a] = DW'(model_root(int'(orig[a])));
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    starts0 = n_starts;
    eng_lat = lat;
    busy_gaps = 0;
    @(negedge CLK);
    FirstAddr = AW'(first);
    LastAddr = AW'(last);
    Go = 1'b1;
    cycles = 0;
    while (1) begin
      @(posedge CLK);
      cycles++;
      @(negedge CLK);
      Go = 1'b0;
      eng_done_force = 1'b0;
      if (glitch && cycles == 1) eng_done_force = 1'b1;
      if (glitch && cycles == 5) begin
        Go = 1'b1;
        FirstAddr = AW'(first + 3);
        LastAddr = AW'(first + 7);
      end
      if (!Busy) busy_gaps++;
      if (Done) break;
      if (cycles > 3000) begin
        check_val("done_timeout", 1, 0);
        break;
      end
    end
    eng_done_force = 1'b0;
    check_val("busy_hold", busy_gaps, 0);
    check_val("word_cnt", WordCnt, n);
    check_val("eng_starts", n_starts - starts0, n);
    check_val("wr_count", wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      a = (first + i) % DEPTH;
      check_val("wr_addr", wr_addr_q[i], a);
      check_val("wr_data", wr_data_q[i], int'(expm[a]));
    end
    for (int j = 0; j < DEPTH; j++) check_val("ram_word", mem[j], expm[j]);
    @(negedge CLK);
    check_val("done_single", Done, 0);
    check_val("busy_after", Busy, 0);
    check_val("cnt_hold", WordCnt, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_we"}, WE, 0);
    check_val({tag, "_addr"}, Addr, 0);
    check_val({tag, "_wdata"}, WData, 0);
    check_val({tag, "_start"}, EngStart, 0);
    check_val({tag, "_engn"}, EngN, 0);
    check_val({tag, "_busy"}, Busy, 0);
    check_val({tag, "_done"}, Done, 0);
    check_val({tag, "_cnt"}, WordCnt, 0);
`ifdef SQRT_SEQ_CHECK_EN
    check_val({tag, "_chkerr"}, ChkErr, 0);
`endif
  endtask

  initial begin
    int cyc, k, first, last;
    logic [DW-1:0] plan_in [DEPTH];
    logic [DW-1:0] plan_out [DEPTH];
    logic [DW-1:0] pre;
    plan_in  = '{1, 4, 9, 16, 25, 36, 49, 64, 0, 6, 13, 21, 27, 44, 225, 255};
    plan_out = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 2, 3, 4, 5, 6, 15, 15};
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    ResetN = 1'b1;
    @(negedge CLK);

    // Full window, table from the test plan.
    mem = plan_in;
    run_batch(0, 15, 2, 1'b0, cyc);
    for (int i = 0; i < DEPTH; i++) check_val("plan_tbl", mem[i], plan_out[i]);
    check_val("plan_cnt16", WordCnt, 16);

    // Single word window and its latency.
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 7);
    mem[5] = 8'd36;
    run_batch(5, 5, 2, 1'b0, cyc);
    check_val("single_val", mem[5], 6);
    check_val("single_lat", cyc, 6 + 2 + 1);

    // Wrapping window.
    mem[14] = 8'd225; mem[15] = 8'd255; mem[0] = 8'd0; mem[1] = 8'd1;
    run_batch(14, 1, 1, 1'b0, cyc);
    check_val("wrap_14", mem[14], 15);
    check_val("wrap_1", mem[1], 1);

    // Stray Go and early EngDone must not disturb the batch.
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 255));
    run_batch(2, 9, 3, 1'b1, cyc);

    // Randomized windows, contents and engine latencies.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 255));
      first = int'($urandom_range(0, DEPTH - 1));
      last = int'($urandom_range(0, DEPTH - 1));
      if (t == 0) last = (first + DEPTH - 1) % DEPTH;
      run_batch(first, last, int'($urandom_range(1, 5)), 1'b0, cyc);
    end

    // Asynchronous reset during a write.
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
    pre = mem[3];
    @(negedge CLK);
    FirstAddr = 4'd3;
    LastAddr = 4'd9;
    Go = 1'b1;
    @(negedge CLK);
    Go = 1'b0;
    k = 0;
    while (!WE && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check_val("we_seen", WE, 1);
    ResetN = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(posedge CLK);
    @(negedge CLK);
    check_val("arst_nowrite", mem[3], pre);
    ResetN = 1'b1;
    run_batch(3, 9, 1, 1'b0, cyc);

`ifdef SQRT_SEQ_CHECK_EN
    mem = plan_in;
    corrupt_25 = 1'b1;
    run_batch(0, 15, 1, 1'b0, cyc);
    check_val("chk_err", ChkErr, 1);
    check_val("chk_addr", ChkAddr, 4);
    check_val("chk_ram4", mem[4], 3);
    corrupt_25 = 1'b0;
    run_batch(0, 0, 1, 1'b0, cyc);
    check_val("chk_clear", ChkErr, 0);
`endif

    check_val("zext_width", SEQ_ZEXT_W, DW - RW);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_ram_sequencer.md
Name: sqrt_ram_sequencer

Overview:
Controller that sweeps a contiguous address window of the 16x8 synchronous RAM and feeds each word through the shared square-root engine. It writes each root back in place, zero-extended.
Sits between the RAM (single port, 1-cycle registered read) and the sqrt engine (start/done handshake). Replaces ad-hoc bench sequencing with one Go-triggered batch job.

Parameters:
ADDR_W, 4, RAM address width (depth 2**ADDR_W)
DATA_W, 8, RAM word / radicand width
ROOT_W, 4, root width (DATA_W/2)

Ports:
CLK  in  1  clock, rising edge
ResetN  in  1  reset, asynchronous, active-low
Go  in  1  batch start; sampled only in IDLE
FirstAddr  in  ADDR_W  first address of window; captured on accepted Go
LastAddr  in  ADDR_W  last address (inclusive); captured on accepted Go
Addr  out  ADDR_W  RAM address
WData  out  DATA_W  RAM write data
WE  out  1  RAM write enable
RData  in  DATA_W  RAM read data, valid the cycle after Addr is presented
EngStart  out  1  one-cycle start pulse to sqrt engine
EngN  out  DATA_W  radicand to engine; held stable from EngStart until EngDone
EngDone  in  1  engine result valid
EngRoot  in  ROOT_W  engine result
Busy  out  1  high from accepted Go until the cycle after Done
Done  out  1  one-cycle pulse at batch end
WordCnt  out  ADDR_W+1  words completed in current/last batch

Behaviour:
- Reset: state IDLE; Addr=0, WData=0, WE=0, EngStart=0, EngN=0, Busy=0, Done=0, WordCnt=0. Async reset mid-batch aborts immediately; WE deasserts without waiting for a clock; no partial write.
- States: IDLE, RD_ADDR, RD_WAIT, START, WAIT, WRITE, NEXT, FIN.
- IDLE: Go=1 -> capture First/Last; Addr<=FirstAddr; WordCnt<=0; Busy<=1; -> RD_ADDR.
- RD_ADDR: WE=0, Addr stable -> RD_WAIT.
- RD_WAIT: RAM latency cycle. At the end of this cycle EngN<=RData -> START.
- START: EngStart=1 for exactly this cycle -> WAIT.
- WAIT: EngDone sampled only here. When EngDone=1, capture EngRoot -> WRITE. EngDone outside WAIT is ignored.
- WRITE: WE=1 for one cycle, WData={{DATA_W-ROOT_W}{1'b0},root}, Addr unchanged -> NEXT.
- NEXT: WordCnt+1.
  - If Addr==LastAddr -> FIN.
  - Otherwise Addr<=Addr+1, modulo 2**ADDR_W -> RD_ADDR.
- Wrap: LastAddr<FirstAddr means the window wraps past the top address (e.g. 14,15,0,1). First==Last processes exactly 1 word. A full window (Last=First-1) processes 16 words; WordCnt=16 needs the extra bit.
- FIN: Done=1 for one cycle; Busy<=0; -> IDLE. WordCnt holds until the next accepted Go.
- Go while Busy is ignored (no queuing). Go held high through FIN starts a new batch on the first IDLE cycle.
- Per-word latency: 6 cycles plus engine cycles (EngStart to EngDone).
- EngN must not change while the engine computes.

Optional Feature:
- Macro: SQRT_SEQ_CHECK_EN.
- When defined:
  - Adds output ChkErr (1, sticky until next accepted Go) and output ChkAddr (ADDR_W).
  - In WRITE, the block verifies root*root <= EngN < (root+1)*(root+1), computed at DATA_W+2 bits.
  - On the first violation it sets ChkErr and latches ChkAddr=Addr. The write still occurs.
- When undefined: no checker logic and no extra ports.

Decomposition:
- Shared package/include:
  - state encoding localparams (3-bit)
  - ADDR_W / DATA_W / ROOT_W defaults
  - zero-extend width constant
- One natural sub-module: sqrt_seq_addr_gen. It holds the First/Last capture, the wrapping increment, the last-word compare and WordCnt.
- FSM and checker stay in the top.

Test Plan:
- RAM[0..15]={1,4,9,16,25,36,49,64,0,6,13,21,27,44,225,255}; Go with First=0, Last=15.
  - RAM becomes {1,2,3,4,5,6,7,8,0,2,3,4,5,6,15,15}.
  - WordCnt=16; exactly one Done pulse.
- First=Last=5, RAM[5]=36.
  - Exactly one EngStart; RAM[5]=6; all other words unchanged.
  - Done exactly 6+engine_latency+1 cycles after Go.
- Wrap: First=14, Last=1, RAM[14]=225, RAM[15]=255, RAM[0]=0, RAM[1]=1.
  - Results 15, 15, 0, 1 written in address order 14,15,0,1; WordCnt=4.
- Go pulsed mid-batch, and EngDone forced high during RD_WAIT.
  - Neither has any effect; the batch completes normally.
  - Busy stays high throughout.
- ResetN low during a WRITE cycle.
  - WE falls asynchronously; all outputs reach their reset values.
  - A fresh Go then restarts cleanly from FirstAddr.
- With SQRT_SEQ_CHECK_EN: engine model returns 3 for N=25 at Addr 4.
  - ChkErr=1, ChkAddr=4; RAM[4]=3; batch still completes.
  - Next Go clears ChkErr.
